// File: rtl/rand_draw_arbiter.sv
// Round-robin arbiter sharing one 13-bit Fibonacci LFSR among requesters.
// Each draw is range-limited by mask-and-reject with a bounded fallback.
module rand_draw_arbiter #(
  parameter int               NUM_REQ   = 4,
  parameter int               WIDTH     = 13,
  parameter int               SHIFTS    = 13,
  parameter logic [WIDTH-1:0] SEED      = 13'h1FFF,
  parameter int               MAX_RETRY = 7,
  localparam int              OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] limit_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rnd_out,
  output logic                     rnd_valid,
  output logic                     busy,
  output logic [OW-1:0]            owner
);

  localparam int CW = $clog2(SHIFTS + 1);
  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == '0) ? '1 : SEED;
  localparam logic [CW-1:0] LAST_SHIFT = CW'(SHIFTS - 1);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [OW:0] NREQ = (OW + 1)'(NUM_REQ);
  localparam logic [OW-1:0] LAST_REQ = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    DELIVER
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] limit_q;
  logic [OW-1:0]    rr_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       retry_q;

  logic [2*NUM_REQ-1:0] dbl_d;
  logic [OW:0]          sum_d;
  logic                 gnt_found_d;
  logic [OW-1:0]        gnt_idx_d;
  logic [WIDTH-1:0]     gnt_lim_d;
  logic [WIDTH-1:0]     mask_d;
  logic [WIDTH-1:0]     cand_d;
  logic                 fb_d;

  assign fb_d   = lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
  assign cand_d = lfsr_q & mask_d;

  // Rotate so the rr pointer sits at bit 0; lowest set bit wins.
  always_comb begin
    dbl_d       = {req, req} >> rr_q;
    gnt_found_d = 1'b0;
    sum_d       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl_d[i]) begin
        gnt_found_d = 1'b1;
        sum_d       = {1'b0, rr_q} + (OW + 1)'(i);
      end
    end
    if (sum_d >= NREQ) begin
      sum_d = sum_d - NREQ;
    end
    gnt_idx_d = sum_d[OW-1:0];
  end

  always_comb begin
    gnt_lim_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_d == OW'(i)) begin
        gnt_lim_d = limit_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Smear the limit downward: smallest 2^k-1 covering it.
  always_comb begin
    mask_d = limit_q;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      mask_d = mask_d | (mask_d >> s);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      limit_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      ack       <= '0;
      rnd_out   <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
      owner     <= '0;
    end else begin
      ack       <= '0;
      rnd_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_found_d) begin
            owner   <= gnt_idx_d;
            limit_q <= gnt_lim_d;
            cnt_q   <= '0;
            retry_q <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr_q <= {lfsr_q[WIDTH-2:0], fb_d};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (cand_d <= limit_q) begin
            rnd_out   <= cand_d;
            rnd_valid <= 1'b1;
            ack       <= NUM_REQ'(1) << owner;
            state_q   <= DELIVER;
          end else if (retry_q != RETRY_LIM) begin
            retry_q <= retry_q + 1'b1;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            rnd_out   <= cand_d - limit_q - 1'b1;
            rnd_valid <= 1'b1;
            ack       <= NUM_REQ'(1) << owner;
            state_q   <= DELIVER;
          end
        end
        DELIVER: begin
          busy    <= 1'b0;
          rr_q    <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Randomized bench for rand_draw_arbiter against a draw-level model.
// A second instance with MAX_RETRY=0 exercises the fallback path.
module tb_rand_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = '0;
  logic [51:0] limit_in = '0;
  logic [3:0]  ack;
  logic [12:0] rnd_out;
  logic        rnd_valid;
  logic        busy;
  logic [1:0]  owner;

  logic [3:0]  req1 = '0;
  logic [51:0] limit1 = '0;
  logic [3:0]  ack1;
  logic [12:0] rnd1;
  logic        valid1;
  logic        busy1;
  logic [1:0]  owner1;

  int checks = 0;
  int errors = 0;
  int m_lfsr;
  int m_rr;
  int lim_a[4];

  always #5 clock = ~clock;

  rand_draw_arbiter u0 (
    .clock(clock), .reset(reset), .req(req),
    .limit_in(limit_in), .ack(ack), .rnd_out(rnd_out),
    .rnd_valid(rnd_valid), .busy(busy), .owner(owner)
  );

  rand_draw_arbiter #(.MAX_RETRY(0)) u1 (
    .clock(clock), .reset(reset), .req(req1),
    .limit_in(limit1), .ack(ack1), .rnd_out(rnd1),
    .rnd_valid(valid1), .busy(busy1), .owner(owner1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int step(input int x);
    int fb;
    fb = ((x >> 12) ^ (x >> 3) ^ (x >> 2) ^ x) & 1;
    return ((x << 1) | fb) & 'h1FFF;
  endfunction

  // One draw: returns value and number of 13-step attempts used.
  task automatic mdraw(input int lim, input int maxr,
                       inout int lf, output int res, output int att);
    int m;
    int cand;
    m = 0;
    while (m < lim) m = m * 2 + 1;
    cand = 0;
    for (int a = 0; a <= maxr; a++) begin
      for (int s = 0; s < 13; s++) lf = step(lf);
      cand = lf & m;
      if (cand <= lim) begin
        res = cand;
        att = a + 1;
        return;
      end
    end
    res = cand - lim - 1;
    att = maxr + 1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    req1  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(rnd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_rnd", int'(rnd_out), 0);
    @(negedge clock);
    reset  = 1'b1;
    m_lfsr = 'h1FFF;
    m_rr   = 0;
  endtask

  // Hold all requesters in mask; drop each bit right after its ack.
  task automatic serve(input int mask);
    int pend, idx, res, att, n, expn, j;
    bit first, got;
    @(negedge clock);
    limit_in = {13'(lim_a[3]), 13'(lim_a[2]),
                13'(lim_a[1]), 13'(lim_a[0])};
    req   = 4'(mask);
    pend  = mask & 'hF;
    first = 1'b1;
    while (pend != 0) begin
      idx = 0;
      for (int k = 3; k >= 0; k--) begin
        j = (m_rr + k) % 4;
        if (((pend >> j) & 1) != 0) idx = j;
      end
      mdraw(lim_a[idx], 7, m_lfsr, res, att);
      expn = (first ? 1 : 2) + 14 * att;
      n = 0;
      got = 1'b0;
      while (!got && n < 400) begin
        @(posedge clock);
        #1;
        n++;
        chk("ack_onehot", int'($countones(ack) <= 1), 1);
        if (ack != '0) got = 1'b1;
      end
      if (!got) begin
        chk("ack_timeout", 0, 1);
        req = '0;
        return;
      end
      chk("latency", n, expn);
      chk("ack_bit", int'(ack), 1 << idx);
      chk("owner", int'(owner), idx);
      chk("valid", int'(rnd_valid), 1);
      chk("rnd", int'(rnd_out), res);
      chk("rnd_le_lim", int'(int'(rnd_out) <= lim_a[idx]), 1);
      chk("busy_ack", int'(busy), 1);
      req   = req & ~(4'b0001 << idx);
      pend  = pend & ~(1 << idx);
      m_rr  = (idx + 1) % 4;
      first = 1'b0;
    end
    @(posedge clock);
    #1;
    chk("busy_after", int'(busy), 0);
    chk("valid_after", int'(rnd_valid), 0);
    chk("ack_after", int'(ack), 0);
  endtask

  int n1;
  int sel;

  initial begin
    do_reset();
    lim_a = '{'h1FFF, 0, 0, 0};
    serve(1);
    chk("plan_085E", int'(rnd_out), 'h085E);

    do_reset();
    lim_a = '{'h00FF, 0, 0, 0};
    serve(1);
    chk("plan_005E", int'(rnd_out), 'h005E);

    do_reset();
    lim_a = '{80, 0, 0, 0};
    serve(1);

    // Fallback instance: first candidate 94 rejected, 94-81 delivered.
    do_reset();
    @(negedge clock);
    limit1 = {39'd0, 13'd80};
    req1   = 4'b0001;
    n1 = 0;
    while (ack1 == '0 && n1 < 100) begin
      @(posedge clock);
      #1;
      n1++;
    end
    req1 = '0;
    chk("fb_latency", n1, 15);
    chk("fb_ack", int'(ack1), 1);
    chk("fb_rnd", int'(rnd1), 13);

    do_reset();
    lim_a = '{'h1FFF, 'h1FFF, 'h1FFF, 'h1FFF};
    serve(15);

    // Reset in the middle of SHIFT abandons the draw.
    do_reset();
    @(negedge clock);
    limit_in = {39'd0, 13'h1FFF};
    req = 4'b0001;
    repeat (6) begin
      @(posedge clock);
      #1;
      chk("mid_noack", int'(ack), 0);
    end
    chk("mid_busy", int'(busy), 1);
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    @(posedge clock);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'(ack), 0);
    @(negedge clock);
    reset  = 1'b1;
    m_lfsr = 'h1FFF;
    m_rr   = 0;
    lim_a = '{'h1FFF, 0, 0, 0};
    serve(1);
    chk("abort_085E", int'(rnd_out), 'h085E);

    for (int t = 0; t < 15; t++) begin
      for (int q = 0; q < 4; q++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: lim_a[q] = 0;
          1: lim_a[q] = 'h1FFF;
          2: lim_a[q] = $urandom_range(0, 300);
          default: lim_a[q] = $urandom_range(0, 'h1FFF);
        endcase
      end
      serve($urandom_range(1, 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
